// File: rtl/dff_bank_pkg.sv
// Shared types and constants for the arbitrated register bank.
// FSM state encoding, hold counter sizing and a constant clog2 helper.
package dff_bank_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    localparam int unsigned HOLD_MAX = 15;
    localparam int unsigned CNT_W    = 4;

    // Index width for n items; never below 1 so n=1/2 still yield a legal vector.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = (n > 0) ? n - 1 : 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/dff_bank_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// scanning ptr, ptr+1, ... modulo NREQ.
module rr_pick
    import dff_bank_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned PW   = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic            any,
    output logic [PW-1:0]   idx
);

    int unsigned cand;

    always_comb begin
        any  = 1'b0;
        idx  = '0;
        cand = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = (32'(ptr) + k) % NREQ;
            if (!any && req[PW'(cand)]) begin
                any = 1'b1;
                idx = PW'(cand);
            end
        end
    end

endmodule

// File: rtl/dff_bank_arbiter.sv
// Shared WIDTH-bit register bank written by NREQ requesters under round-robin
// arbitration, with a hold window after each grant.
module dff_bank_arbiter
    import dff_bank_pkg::*;
#(
    parameter  int unsigned NREQ        = 4,
    parameter  int unsigned WIDTH       = 8,
    parameter  int unsigned HOLD_CYCLES = 2,
    localparam int unsigned PW          = clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] wdata,
    input  logic                  clr,
    output logic [NREQ-1:0]       gnt,
    output logic [WIDTH-1:0]      q,
    output logic                  q_valid,
    output logic [PW-1:0]         owner,
    output logic                  busy
);

    localparam logic [CNT_W-1:0] HOLD_LOAD =
        (HOLD_CYCLES == 0) ? '0 : CNT_W'(HOLD_CYCLES - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [PW-1:0]     ptr_q,   ptr_d;
    logic [PW-1:0]     owner_q, owner_d;
    logic [NREQ-1:0]   gnt_q,   gnt_d;
    logic [WIDTH-1:0]  bank_q,  bank_d;
    logic              valid_q, valid_d;
    logic              busy_q,  busy_d;

    logic              pick_any;
    logic [PW-1:0]     pick_idx;
    logic [WIDTH-1:0]  pick_data;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req (req),
        .ptr (ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    assign pick_data = wdata[32'(pick_idx) * WIDTH +: WIDTH];

    // Next-state: arbitrate in IDLE, count down in HOLD; clr overrides bank contents.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        gnt_d   = '0;
        bank_d  = bank_q;
        valid_d = valid_q;
        busy_d  = busy_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_any && !clr) begin
                    gnt_d   = NREQ'(1) << pick_idx;
                    bank_d  = pick_data;
                    owner_d = pick_idx;
                    valid_d = 1'b1;
                    ptr_d   = (32'(pick_idx) == NREQ - 1) ? '0 : pick_idx + 1'b1;
                    if (HOLD_CYCLES != 0) begin
                        state_d = ST_HOLD;
                        cnt_d   = HOLD_LOAD;
                        busy_d  = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (clr) begin
            bank_d  = '0;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            owner_q <= '0;
            gnt_q   <= '0;
            bank_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            gnt_q   <= gnt_d;
            bank_q  <= bank_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign gnt     = gnt_q;
    assign q       = bank_q;
    assign q_valid = valid_q;
    assign owner   = owner_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Scoreboard bench for dff_bank_arbiter: a HOLD_CYCLES=2 instance and a
// HOLD_CYCLES=0 instance driven by directed and random stimulus.
module tb_dff_bank_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int HOLD  = 2;

    typedef struct {
        int         idx;
        logic [7:0] data;
    } exp_t;

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic        clr  = 1'b0;
    logic        clr2 = 1'b0;
    logic [3:0]  req  = '0;
    logic [3:0]  req2 = '0;
    logic [31:0] wdata = '0;

    logic [3:0]  gnt,     gnt2;
    logic [7:0]  q,       q2;
    logic        q_valid, q_valid2;
    logic        busy,    busy2;
    logic [1:0]  owner,   owner2;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t sb[$];
    exp_t e;

    // Reference state: grant spacing is tracked as "earliest edge allowed to grant".
    int         cyc       = 0;
    int         m_ptr     = 0;
    int         m_next_ok = 0;
    int         m_owner   = 0;
    logic [7:0] m_q       = '0;
    logic       m_valid   = 1'b0;
    logic       m_busy    = 1'b0;
    int         m2_ptr    = 0;
    logic [3:0] m2_gnt    = '0;
    logic [7:0] m2_q      = '0;
    int         w, w2;

    always #5 clk = ~clk;

    dff_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .rst(rst), .req(req), .wdata(wdata), .clr(clr),
        .gnt(gnt), .q(q), .q_valid(q_valid), .owner(owner), .busy(busy)
    );

    dff_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .HOLD_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .req(req2), .wdata(wdata), .clr(clr2),
        .gnt(gnt2), .q(q2), .q_valid(q_valid2), .owner(owner2), .busy(busy2)
    );

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic [3:0] r, input logic c, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
            req = r;
            clr = c;
        end
    endtask

    task automatic chk_reset_values();
        chk("rst_q",       int'(q),       0);
        chk("rst_gnt",     int'(gnt),     0);
        chk("rst_q_valid", int'(q_valid), 0);
        chk("rst_busy",    int'(busy),    0);
        chk("rst_owner",   int'(owner),   0);
    endtask

    // Reference model, evaluated on each active edge or reset assertion.
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_ptr = 0; m_next_ok = 0; m_owner = 0;
                m_q = '0; m_valid = 1'b0; m_busy = 1'b0;
                m2_ptr = 0; m2_gnt = '0; m2_q = '0;
                sb.delete();
            end else begin
                cyc++;
                w = pick(req, m_ptr);
                if (clr) begin
                    m_q = '0;
                    m_valid = 1'b0;
                end else if (cyc >= m_next_ok && w >= 0) begin
                    sb.push_back('{w, wdata[w*8 +: 8]});
                    m_q       = wdata[w*8 +: 8];
                    m_valid   = 1'b1;
                    m_owner   = w;
                    m_ptr     = (w + 1) % NREQ;
                    m_next_ok = cyc + HOLD + 1;
                end
                m_busy = (cyc < m_next_ok - 1);

                w2 = pick(req2, m2_ptr);
                m2_gnt = '0;
                if (w2 >= 0) begin
                    m2_gnt[w2] = 1'b1;
                    m2_q       = wdata[w2*8 +: 8];
                    m2_ptr     = (w2 + 1) % NREQ;
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever a grant is presented.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (gnt != '0) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_gnt: got %0h expected 0 at %0t", gnt, $time);
                    end else begin
                        e = sb.pop_front();
                        chk("gnt",       int'(gnt),   1 << e.idx);
                        chk("gnt_owner", int'(owner), e.idx);
                        chk("gnt_q",     int'(q),     int'(e.data));
                    end
                end else if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("gnt_missing", int'(gnt), 1 << e.idx);
                end
                chk("q",       int'(q),       int'(m_q));
                chk("q_valid", int'(q_valid), int'(m_valid));
                chk("busy",    int'(busy),    int'(m_busy));
                chk("owner",   int'(owner),   m_owner);
                chk("gnt_hold0",  int'(gnt2),  int'(m2_gnt));
                chk("q_hold0",    int'(q2),    int'(m2_q));
                chk("busy_hold0", int'(busy2), 0);
            end
        end
    end

    initial begin
        @(negedge clk);
        #1;
        chk_reset_values();
        rst = 1'b0;

        // Single requester with hold spacing; alternating pair on the HOLD=0 instance.
        wdata = 32'h00A5_0000;
        req2  = 4'b1010;
        step(4'b0100, 1'b0, 10);
        step(4'b0000, 1'b0, 3);

        // All requesting: fairness and pointer wrap.
        wdata = 32'h4433_2211;
        step(4'b1111, 1'b0, 15);
        step(4'b0000, 1'b0, 4);

        // clr collides with a pending grant, then the grant follows.
        step(4'b0001, 1'b1, 1);
        step(4'b0001, 1'b0, 1);
        step(4'b0000, 1'b0, 3);

        // Reset in the middle of a hold window; pointer restarts at 0.
        wdata = 32'h0000_5A00;
        step(4'b0010, 1'b0, 1);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk_reset_values();
        @(negedge clk);
        #1;
        rst = 1'b0;
        step(4'b0010, 1'b0, 4);
        step(4'b0000, 1'b0, 3);

        // Random traffic with occasional clr and reset.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            #1;
            req   = 4'($urandom);
            req2  = 4'($urandom);
            wdata = $urandom;
            clr   = ($urandom_range(0, 9) == 0);
            rst   = ($urandom_range(0, 99) == 0);
        end
        @(negedge clk);
        #1;
        rst  = 1'b0;
        req  = '0;
        req2 = '0;
        clr  = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        chk("sb_drain", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
